// File: rtl/audio_interp.sv
// audio_interp: linear interpolator from a slow audio sample stream up to a
// fast output beat stream. RATIO output beats are produced per input sample
// by stepping a fixed-point accumulator from cur toward nxt.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   s00_axis_tvalid/tdata   input samples (signed 16-bit in tdata[15:0])
//   s00_axis_tready         high while the pending slot is empty
//   m00_axis_tready         downstream step enable
//   m00_axis_tvalid/tdata   interpolated sample, sign-extended to full width
//   m00_axis_tlast          last beat of an interpolation segment
//   m00_axis_tstrb          constant all ones
//
// Optional feature: define AUDIO_INTERP_PREEMPH_EN to apply a first-order
// pre-emphasis (gain PREEMPH_K / 4096 on the sample difference) before storage.
module audio_interp #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int RATIO                  = 5208,
  parameter int FRAC_BITS              = 24
`ifdef AUDIO_INTERP_PREEMPH_EN
  ,
  parameter int PREEMPH_K              = 14746
`endif
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

  // 16 integer bits + sign + headroom for slope products and rounding overshoot
  localparam int ACC_W = FRAC_BITS + 20;
  localparam int CNT_W = $clog2(RATIO);
  localparam longint unsigned ONE   = 64'd1 << FRAC_BITS;
  localparam longint unsigned INC_U = (ONE + 64'(RATIO / 2)) / 64'(RATIO);
  localparam logic signed [FRAC_BITS+1:0] INC = (FRAC_BITS + 2)'(INC_U);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  typedef enum logic [1:0] {S_EMPTY, S_PRIME, S_RUN, S_STARVE} state_t;

  state_t                    r_state;
  logic signed [15:0]        r_cur;
  logic signed [15:0]        r_nxt;
  logic signed [15:0]        r_pend;
  logic                      r_pend_valid;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   r_slope;

  logic signed [15:0]        w_raw;
  logic signed [15:0]        w_in;
  logic signed [15:0]        w_shift_in;
  logic                      w_iacc;
  logic                      w_ohs;
  logic                      w_seg_end;
  logic signed [ACC_W-FRAC_BITS-1:0] w_int;
  logic signed [15:0]        w_sat;
  logic signed [15:0]        w_out;

  function automatic logic signed [ACC_W-1:0] f_base(input logic signed [15:0] s);
    logic signed [ACC_W-1:0] t;
    t = ACC_W'(s);
    return t <<< FRAC_BITS;
  endfunction

  function automatic logic signed [ACC_W-1:0] f_slope(input logic signed [15:0] a,
                                                      input logic signed [15:0] b);
    logic signed [16:0]      d;
    logic signed [ACC_W-1:0] dx;
    logic signed [ACC_W-1:0] ix;
    d  = 17'(b) - 17'(a);
    dx = ACC_W'(d);
    ix = ACC_W'(INC);
    return dx * ix;
  endfunction

  assign w_raw = s00_axis_tdata[15:0];

  generate
    if (C_S00_AXIS_TDATA_WIDTH > 16) begin : g_unused_in
      logic w_unused_hi;
      assign w_unused_hi = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:16];
    end
  endgenerate

`ifdef AUDIO_INTERP_PREEMPH_EN
  logic signed [15:0] r_xprev;

  function automatic logic signed [15:0] f_preemph(input logic signed [15:0] x,
                                                   input logic signed [15:0] xp);
    logic signed [16:0] d;
    logic signed [39:0] p;
    logic signed [39:0] y;
    d = 17'(x) - 17'(xp);
    p = (40'(d) * 40'(PREEMPH_K)) >>> 12;
    y = 40'(x) + p;
    if (y > 40'sd32767)       return 16'sh7FFF;
    else if (y < -40'sd32768) return 16'sh8000;
    else                      return y[15:0];
  endfunction

  assign w_in = f_preemph(w_raw, r_xprev);
`else
  assign w_in = w_raw;
`endif

  assign s00_axis_tready = !r_pend_valid;
  assign w_iacc          = s00_axis_tvalid && !r_pend_valid;
  assign w_ohs           = (r_state == S_RUN) && m00_axis_tready;
  assign w_seg_end       = w_ohs && (r_cnt == LAST);
  // A sample arriving on the segment-end cycle is used directly as the new
  // nxt, which is equivalent to parking it in pend and shifting immediately.
  assign w_shift_in      = r_pend_valid ? r_pend : w_in;

  assign w_int = r_acc[ACC_W-1:FRAC_BITS];

  always_comb begin
    w_sat = w_int[15:0];
    if (w_int > (ACC_W-FRAC_BITS)'(32767))       w_sat = 16'sh7FFF;
    else if (w_int < -(ACC_W-FRAC_BITS)'(32768)) w_sat = 16'sh8000;
  end

  always_comb begin
    w_out = '0;
    case (r_state)
      S_RUN:    w_out = w_sat;
      S_STARVE: w_out = r_nxt;
      default:  w_out = '0;
    endcase
  end

  assign m00_axis_tvalid = (r_state == S_RUN) || (r_state == S_STARVE);
  assign m00_axis_tlast  = (r_state == S_RUN) && (r_cnt == LAST);
  assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(w_out);
  assign m00_axis_tstrb  = '1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= S_EMPTY;
      r_cur        <= '0;
      r_nxt        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_slope      <= '0;
`ifdef AUDIO_INTERP_PREEMPH_EN
      r_xprev      <= '0;
`endif
    end else begin
`ifdef AUDIO_INTERP_PREEMPH_EN
      if (w_iacc) r_xprev <= w_raw;
`endif
      case (r_state)
        S_EMPTY: begin
          if (w_iacc) begin
            r_cur   <= w_in;
            r_state <= S_PRIME;
          end
        end
        S_PRIME: begin
          if (w_iacc) begin
            r_nxt   <= w_in;
            r_acc   <= f_base(r_cur);
            r_slope <= f_slope(r_cur, w_in);
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_seg_end) begin
            r_cnt <= '0;
            if (r_pend_valid || w_iacc) begin
              r_cur        <= r_nxt;
              r_nxt        <= w_shift_in;
              r_pend_valid <= 1'b0;
              r_acc        <= f_base(r_nxt);
              r_slope      <= f_slope(r_nxt, w_shift_in);
            end else begin
              r_state <= S_STARVE;
            end
          end else begin
            if (w_ohs) begin
              r_acc <= r_acc + r_slope;
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_iacc) begin
              r_pend       <= w_in;
              r_pend_valid <= 1'b1;
            end
          end
        end
        S_STARVE: begin
          if (w_iacc) begin
            r_cur   <= r_nxt;
            r_nxt   <= w_in;
            r_acc   <= f_base(r_nxt);
            r_slope <= f_slope(r_nxt, w_in);
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_interp.sv
// Testbench for audio_interp (RATIO=4, FRAC_BITS=24). The reference model
// keeps the list of stored samples and the current segment/beat position and
// computes each expected beat from the linear interpolation formula.
module tb_audio_interp;

  localparam int RATIO = 4;
  localparam int FRAC  = 24;
  localparam int W     = 32;
  localparam longint INC = ((longint'(1) <<< FRAC) + RATIO / 2) / RATIO;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_tvalid;
  logic [W-1:0]   s_tdata;
  logic           s_tready;
  logic           m_tready;
  logic           m_tvalid;
  logic [W-1:0]   m_tdata;
  logic           m_tlast;
  logic [W/8-1:0] m_tstrb;

  always #5 clk = ~clk;

  audio_interp #(
    .C_S00_AXIS_TDATA_WIDTH(W),
    .C_M00_AXIS_TDATA_WIDTH(W),
    .RATIO(RATIO),
    .FRAC_BITS(FRAC)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tdata(s_tdata),
    .s00_axis_tready(s_tready),
    .m00_axis_tready(m_tready),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tdata(m_tdata),
    .m00_axis_tlast(m_tlast),
    .m00_axis_tstrb(m_tstrb)
  );

  int total = 0;
  int bad   = 0;

  logic signed [15:0] q[$];     // samples stored by the DUT, in order
  logic signed [15:0] feed[$];  // samples waiting to be offered
  logic signed [15:0] obs[$];   // data seen on output handshakes
  int k;                        // segment index: interpolating q[k] -> q[k+1]
  int j;                        // beat within segment
`ifdef AUDIO_INTERP_PREEMPH_EN
  longint xprev;
`endif

  function automatic logic signed [15:0] sat16(input longint v);
    if (v > 32767)  return 16'sh7FFF;
    if (v < -32768) return 16'sh8000;
    return 16'(v);
  endfunction

  function automatic logic signed [15:0] exp_beat(input int kk, input int jj);
    longint a;
    a = (longint'(q[kk]) <<< FRAC)
      + longint'(jj) * (longint'(q[kk+1]) - longint'(q[kk])) * INC;
    return sat16(a >>> FRAC);
  endfunction

  function automatic logic signed [15:0] stored(input logic signed [15:0] x);
`ifdef AUDIO_INTERP_PREEMPH_EN
    return sat16(longint'(x) + (((longint'(x) - xprev) * 14746) >>> 12));
`else
    return x;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    feed.delete();
    obs.delete();
    k = 0;
    j = 0;
`ifdef AUDIO_INTERP_PREEMPH_EN
    xprev = 0;
`endif
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // in_mode: 0 = offer every cycle, 1 = random valid
  // out_mode: 0 = ready always, 1 = toggle 1010.., 2 = random
  // stop_k >= 0: return (at a negedge) right after beat 1 of segment stop_k
  task automatic test_stream(input int n, input int in_mode, input int out_mode,
                             input int stop_k);
    logic ev, er, run, el;
    logic signed [15:0] ed;
    logic [W-1:0] e32;
    for (int c = 0; c < n; c++) begin
      s_tvalid = (feed.size() > 0) && (in_mode == 0 || $urandom_range(1, 0) == 1);
      s_tdata  = $urandom();
      if (feed.size() > 0) s_tdata[15:0] = feed[0];
      m_tready = (out_mode == 0) ? 1'b1 :
                 (out_mode == 1) ? (c % 2 == 0) : ($urandom_range(3, 0) != 0);
      @(negedge clk);
      ev  = (q.size() >= 2);
      run = (q.size() >= k + 2);
      er  = !(q.size() >= k + 3);
      total++;
      if (m_tvalid !== ev) begin
        bad++;
        $display("FAIL tvalid cyc=%0d got=%b exp=%b", c, m_tvalid, ev);
      end
      total++;
      if (s_tready !== er) begin
        bad++;
        $display("FAIL s_tready cyc=%0d got=%b exp=%b", c, s_tready, er);
      end
      if (ev) begin
        ed  = run ? exp_beat(k, j) : q[k];
        el  = run && (j == RATIO - 1);
        e32 = {{(W-16){ed[15]}}, ed};
        total++;
        if (m_tdata !== e32) begin
          bad++;
          $display("FAIL tdata cyc=%0d seg=%0d beat=%0d got=%h exp=%h", c, k, j, m_tdata, e32);
        end
        total++;
        if (m_tlast !== el) begin
          bad++;
          $display("FAIL tlast cyc=%0d seg=%0d beat=%0d got=%b exp=%b", c, k, j, m_tlast, el);
        end
        if (m_tready) begin
          obs.push_back(m_tdata[15:0]);
          if (run) begin
            j++;
            if (j == RATIO) begin
              j = 0;
              k++;
            end
          end
        end
      end
      if (s_tvalid && er) begin
        q.push_back(stored(feed[0]));
`ifdef AUDIO_INTERP_PREEMPH_EN
        xprev = feed[0];
`endif
        void'(feed.pop_front());
      end
      if (stop_k >= 0 && k == stop_k && j == 2) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'h0000_1234;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", m_tvalid); end
    total++;
    if (m_tdata !== '0) begin bad++; $display("FAIL rst_tdata got=%h exp=0", m_tdata); end
    total++;
    if (m_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b exp=0", m_tlast); end
    total++;
    if (s_tready !== 1'b1) begin bad++; $display("FAIL rst_s_tready got=%b exp=1", s_tready); end
    total++;
    if (m_tstrb !== 4'hF) begin bad++; $display("FAIL tstrb got=%h exp=f", m_tstrb); end
    rst      = 1'b0;
    s_tvalid = 1'b0;
    model_reset();
  endtask

  task automatic check_obs(input string name, input int exp_v[], input int n);
    total++;
    if (obs.size() < n) begin
      bad++;
      $display("FAIL %s_count got=%0d exp>=%0d", name, obs.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        total++;
        if (int'(obs[i]) !== exp_v[i]) begin
          bad++;
          $display("FAIL %s[%0d] got=%0d exp=%0d", name, i, int'(obs[i]), exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_ramp();
    int e[] = '{0, 100, 200, 300, 400, 500, 600, 700, 800, 800};
    apply_reset();
    feed = '{16'sd0, 16'sd400, 16'sd800};
    test_stream(20, 0, 0, -1);
`ifndef AUDIO_INTERP_PREEMPH_EN
    check_obs("ramp", e, 10);
`endif
  endtask

  task automatic test_negative();
    int e[] = '{0, -100, -200, -300, -400, -400};
    apply_reset();
    feed = '{16'sd0, -16'sd400};
    test_stream(14, 0, 0, -1);
`ifndef AUDIO_INTERP_PREEMPH_EN
    check_obs("neg", e, 6);
`endif
  endtask

  task automatic test_backpressure();
    int e[] = '{0, 100, 200, 300, 400, 500, 600, 700, 800, 800};
    apply_reset();
    feed = '{16'sd0, 16'sd400, 16'sd800};
    test_stream(36, 0, 1, -1);
`ifndef AUDIO_INTERP_PREEMPH_EN
    check_obs("toggle", e, 10);
`endif
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 24; i++) feed.push_back(16'($urandom()));
    test_stream(120, 0, 0, -1);
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 40; i++) feed.push_back(16'($urandom()));
    test_stream(500, 1, 2, -1);
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < 6; i++) feed.push_back(16'($urandom()));
    test_stream(40, 0, 0, 1);
    total++;
    if (k != 1 || j != 2) begin
      bad++;
      $display("FAIL midrst_reach seg=%0d beat=%0d exp seg=1 beat=2", k, j);
    end
    rst      = 1'b1;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (m_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_tvalid got=%b exp=0", m_tvalid); end
    total++;
    if (m_tdata !== '0) begin bad++; $display("FAIL midrst_tdata got=%h exp=0", m_tdata); end
    total++;
    if (s_tready !== 1'b1) begin bad++; $display("FAIL midrst_s_tready got=%b exp=1", s_tready); end
    model_reset();
    feed.push_back(16'sd1000);
    test_stream(8, 0, 0, -1);
    feed.push_back(-16'sd2000);
    test_stream(16, 0, 0, -1);
  endtask

`ifdef AUDIO_INTERP_PREEMPH_EN
  task automatic test_preemph();
    apply_reset();
    feed = '{16'sd0, 16'sd1000};
    test_stream(12, 0, 0, -1);
    total++;
    if (obs.size() == 0 || int'(obs[obs.size()-1]) !== 4600) begin
      bad++;
      $display("FAIL preemph_hold got=%0d exp=4600",
               obs.size() == 0 ? 0 : int'(obs[obs.size()-1]));
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    test_reset();
    test_ramp();
    test_negative();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
`ifdef AUDIO_INTERP_PREEMPH_EN
    test_preemph();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_interp.md
AUDIO_INTERP -- requirements
Module: audio_interp

Interface
REQ-001 SHALL have parameter C_S00_AXIS_TDATA_WIDTH, default 32, input stream width.
REQ-002 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 32, output stream width.
REQ-003 SHALL have parameter RATIO, default 5208, output beats per input audio sample (≥2).
REQ-004 SHALL have parameter FRAC_BITS, default 24, accumulator fraction bits; localparam INC = round(2^FRAC_BITS / RATIO).
REQ-005 SHALL have port clk_in, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port rst_in, input, 1, synchronous active-high reset.
REQ-007 SHALL have port s00_axis_tvalid, input, 1, audio sample valid.
REQ-008 SHALL have port s00_axis_tdata, input, C_S00_AXIS_TDATA_WIDTH, signed 16-bit sample in [15:0], upper bits ignored.
REQ-009 SHALL have port s00_axis_tready, output, 1, sample accepted when tvalid&tready.
REQ-010 SHALL have port m00_axis_tready, input, 1, downstream FM modulator step enable.
REQ-011 SHALL have port m00_axis_tvalid, output, 1, interpolated sample valid.
REQ-012 SHALL have port m00_axis_tdata, output, C_M00_AXIS_TDATA_WIDTH, signed 16-bit sample sign-extended to full width.
REQ-013 SHALL have port m00_axis_tlast, output, 1, last beat of an interpolation segment.
REQ-014 SHALL have port m00_axis_tstrb, output, C_M00_AXIS_TDATA_WIDTH/8, constant all ones.

Function
REQ-015 SHALL store samples in three registers: cur, nxt, pend (pend with valid flag); s00_axis_tready = !pend_valid.
REQ-016 SHALL implement states EMPTY (no samples), PRIME (cur only), RUN, STARVE.
REQ-017 Transitions SHALL be: EMPTY→PRIME on first accept (cur←sample); PRIME→RUN on second accept (nxt←sample); RUN→STARVE at segment end with pend empty; STARVE→RUN on accept (cur←nxt, nxt←sample).
REQ-018 m00_axis_tvalid SHALL be 0 in EMPTY/PRIME and 1 in RUN/STARVE.
REQ-019 In RUN, segment start SHALL load acc = cur<<FRAC_BITS exactly and slope = (nxt−cur)·INC (signed, no truncation).
REQ-020 Each output handshake in RUN SHALL add slope to acc and increment beat counter; no advance without handshake.
REQ-021 Output SHALL be acc>>>FRAC_BITS, rounded toward −inf, saturated to [−32768, 32767].
REQ-022 Segment end is the handshake with beat counter = RATIO−1; tlast SHALL be 1 on exactly that beat; counter wraps to 0.
REQ-023 At segment end with pend valid, SHALL shift cur←nxt, nxt←pend, clear pend, and present the new segment's first beat next cycle with no tvalid bubble.
REQ-024 In STARVE, output SHALL hold nxt constant, tvalid=1, tlast=0, counter frozen.
REQ-025 Input accept coinciding with segment end with pend empty SHALL fill pend and take the REQ-023 path (no STARVE entry).
REQ-026 Latency: first tvalid SHALL assert the cycle after the second sample is accepted.

Reset
REQ-027 While rst_in=1 at a clock edge: state←EMPTY, all registers, pend_valid, counter, acc cleared; m00_axis_tvalid=0, tlast=0, tdata=0, s00_axis_tready=1 the following cycle.
REQ-028 Reset mid-segment SHALL discard all buffered samples; no partial segment emitted after release.

Configuration
REQ-029 Macro AUDIO_INTERP_PREEMPH_EN defined: accepted samples SHALL pass through a 75 us pre-emphasis y = x + (x − x_prev)·PREEMPH_K>>12 (parameter PREEMPH_K default 14746, x_prev cleared by reset), saturated to 16 bits, before storage.
REQ-030 Macro undefined: samples SHALL be stored unmodified; no pre-emphasis logic or PREEMPH_K effect.

Verification (RATIO=4, FRAC_BITS=24, macro undefined unless stated)
REQ-031 Samples 0, 400, 800, tready=1 -> outputs 0,100,200,300 (tlast on 300), 400,500,600,700, then hold 800 (STARVE).
REQ-032 Samples 0, −400 -> outputs 0,−100,−200,−300; then STARVE holding −400.
REQ-033 RUN, tready toggled 1010… -> acc advances only on handshake cycles; sequence identical to REQ-031.
REQ-034 Flood input continuously -> s00_axis_tready low while pend full; accepts exactly one sample per 4 output beats; no tvalid gap.
REQ-035 rst_in pulsed on 2nd beat of a segment -> next cycle tvalid=0, tdata=0, s00_axis_tready=1; restart needs two new samples.
REQ-036 AUDIO_INTERP_PREEMPH_EN defined, samples 0, 1000 -> stored nxt = 1000+1000·14746>>12 = 4600.
